// File: rtl/request_scheduler.sv
// Request scheduler: sticky pending bits, grant capture and
// valid/ready/done handshake with one shared service unit.
module request_scheduler #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_pulse,
  output logic [N-1:0] arb_req,
  input  logic [N-1:0] arb_grant,
  output logic         svc_valid,
  input  logic         svc_ready,
  output logic [N-1:0] svc_onehot,
  output logic [2:0]   svc_id,
  input  logic         svc_done,
  output logic         busy,
  output logic         overflow,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVE
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [N-1:0]    pending;
  logic [N-1:0]    clr;
  logic [N-1:0]    g;
  logic            g_ok;
  logic            to_hit;
  logic            at_lim;
  logic [TW-1:0]   cnt;

  function automatic logic [2:0] enc(input logic [N-1:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) id = 3'(i);
    end
    return id;
  endfunction

  // Masked grant, one-hot qualification and the accept-time clear.
  always_comb begin
    g      = arb_grant & pending;
    g_ok   = (g != '0) && ((g & (g - 1'b1)) == '0);
    clr    = '0;
    if (state == OFFER && svc_ready) clr = svc_onehot;
    at_lim = (cnt == TW'(TIMEOUT - 1));
    to_hit = (state == SERVE) && !svc_done && at_lim;
  end

  // Next-state logic; done beats a same-cycle timeout.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (g_ok) nxt = OFFER;
      OFFER:   if (svc_ready) nxt = SERVE;
      SERVE:   if (svc_done || at_lim) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Sticky pending bits; a new pulse wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | req_pulse;
      overflow <= |(req_pulse & pending & ~clr);
    end
  end

  // Offered source id, latched in IDLE and dropped on SERVE exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_onehot <= '0;
      svc_id     <= '0;
    end else if (state == IDLE && g_ok) begin
      svc_onehot <= g;
      svc_id     <= enc(g);
    end else if (state == SERVE && nxt == IDLE) begin
      svc_onehot <= '0;
      svc_id     <= '0;
    end
  end

  // Service age counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (state == OFFER && svc_ready) cnt <= '0;
      else if (state == SERVE)         cnt <= cnt + 1'b1;
    end
  end

  assign arb_req   = pending;
  assign svc_valid = (state == OFFER);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_request_scheduler.sv
// Bench for request_scheduler: LSB-first arbiter stub,
// queue-level reference model and directed scenarios.
module tb_request_scheduler;

  localparam int TO = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_pulse;
  logic [7:0] arb_req;
  logic [7:0] arb_grant;
  logic       svc_valid;
  logic       svc_ready;
  logic [7:0] svc_onehot;
  logic [2:0] svc_id;
  logic       svc_done;
  logic       busy;
  logic       overflow;
  logic       timeout_err;

  int checks;
  int failures;

  request_scheduler #(.N(8), .TIMEOUT(TO), .TW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_pulse(req_pulse),
    .arb_req(arb_req),
    .arb_grant(arb_grant),
    .svc_valid(svc_valid),
    .svc_ready(svc_ready),
    .svc_onehot(svc_onehot),
    .svc_id(svc_id),
    .svc_done(svc_done),
    .busy(busy),
    .overflow(overflow),
    .timeout_err(timeout_err)
  );

  assign arb_grant = arb_req & (~arb_req + 8'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: set of pending sources, current job and its phase.
  bit [7:0] m_pend;
  int       m_cur;
  bit       m_offer;
  int       m_age;
  bit       m_ovf;
  bit       m_to;

  always @(posedge clk or negedge rst_n) begin
    bit [7:0] c;
    if (!rst_n) begin
      m_pend = 0; m_cur = -1; m_offer = 0;
      m_age = 0; m_ovf = 0; m_to = 0;
    end else begin
      c = 0;
      if (m_cur >= 0 && m_offer && svc_ready) c = 8'(1 << m_cur);
      m_ovf = |(req_pulse & m_pend & ~c);
      m_to = 0;
      if (m_cur < 0) begin
        for (int i = 7; i >= 0; i--)
          if (m_pend[i]) m_cur = i;
        m_offer = (m_cur >= 0);
      end else if (m_offer) begin
        if (svc_ready) begin
          m_offer = 0;
          m_age = 0;
        end
      end else if (svc_done) begin
        m_cur = -1;
      end else if (m_age == TO - 1) begin
        m_to = 1;
        m_cur = -1;
      end else begin
        m_age++;
      end
      m_pend = (m_pend & ~c) | req_pulse;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_arb_req", arb_req, m_pend);
    chk("m_valid", svc_valid, (m_cur >= 0) && m_offer);
    chk("m_onehot", svc_onehot, (m_cur >= 0) ? (1 << m_cur) : 0);
    chk("m_id", svc_id, (m_cur >= 0) ? m_cur : 0);
    chk("m_busy", busy, m_cur >= 0);
    chk("m_ovf", overflow, m_ovf);
    chk("m_to", timeout_err, m_to);
  end

  task automatic step(input logic [7:0] p, input logic r, input logic d);
    req_pulse = p;
    svc_ready = r;
    svc_done  = d;
    @(posedge clk);
    #1;
    req_pulse = 0;
    svc_ready = 0;
    svc_done  = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    req_pulse = 0; svc_ready = 0; svc_done = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", arb_req, 0);
    rst_n = 1;

    // T2: single source 4
    step(8'h10, 0, 0);
    chk("t2_req", arb_req, 8'h10);
    chk("t2_val0", svc_valid, 0);
    step(0, 0, 0);
    chk("t2_val", svc_valid, 1);
    chk("t2_id", svc_id, 4);
    chk("t2_oh", svc_onehot, 8'h10);
    step(0, 1, 0);
    chk("t2_clr", arb_req, 8'h00);
    chk("t2_serve", svc_valid, 0);
    step(0, 0, 1);
    chk("t2_busy", busy, 0);

    // T3: sources 0 and 7, lowest first
    step(8'h81, 0, 0);
    chk("t3_req0", arb_req, 8'h81);
    step(0, 0, 0);
    chk("t3_id0", svc_id, 0);
    step(0, 1, 0);
    chk("t3_req1", arb_req, 8'h80);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t3_id7", svc_id, 7);
    step(0, 1, 0);
    chk("t3_req2", arb_req, 8'h00);
    step(0, 0, 1);

    // T4: overflow in OFFER, re-pulse in the ready cycle
    step(8'h04, 0, 0);
    step(0, 0, 0);
    chk("t4_id", svc_id, 2);
    step(8'h04, 0, 0);
    chk("t4_ovf", overflow, 1);
    step(0, 0, 0);
    chk("t4_ovf0", overflow, 0);
    step(8'h04, 1, 0);
    chk("t4_keep", arb_req, 8'h04);
    chk("t4_noovf", overflow, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t4_again", svc_id, 2);
    chk("t4_val", svc_valid, 1);
    step(0, 1, 0);
    step(0, 0, 1);

    // T5: timeout, then next pending request
    step(8'h21, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (TO - 1) step(0, 0, 0);
    chk("t5_pre", timeout_err, 0);
    chk("t5_busy", busy, 1);
    step(0, 0, 0);
    chk("t5_to", timeout_err, 1);
    chk("t5_idle", busy, 0);
    chk("t5_req", arb_req, 8'h20);
    step(0, 0, 0);
    chk("t5_to0", timeout_err, 0);
    chk("t5_next", svc_id, 5);
    step(0, 1, 0);
    step(0, 0, 1);

    // T6: done on the last allowed cycle
    step(8'h08, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (TO - 1) step(0, 0, 0);
    step(0, 0, 1);
    chk("t6_to", timeout_err, 0);
    chk("t6_idle", busy, 0);
    step(0, 0, 0);
    chk("t6_to1", timeout_err, 0);

    // T1: async reset mid-SERVE drops everything
    step(8'h02, 0, 0);
    step(0, 0, 0);
    step(8'h40, 1, 0);
    step(0, 0, 0);
    chk("t1_pre", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_req", arb_req, 0);
    chk("t1_oh", svc_onehot, 0);
    chk("t1_val", svc_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t1_idle", busy, 0);
    chk("t1_lost", arb_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
